// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and sticky-error controller for an external 2^W-word register file.
module fifo_ctrl #(
    parameter int W        = 2,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic         clr_err,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic         wr_en,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);
    localparam logic [W:0] DEPTH = (W+1)'(1 << W);
    logic [W-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
    logic [W:0]   count_q, count_d;
    logic         full_q, empty_q, ovf_q, ovf_d, udf_q, udf_d;
    logic         wr_acc, rd_acc;
    assign wr_acc = wr & (~full_q | rd) & ~reset;
    assign rd_acc = rd & ~empty_q;
    always_comb begin
        w_addr_d = wr_acc ? w_addr_q + 1'b1 : w_addr_q;
        r_addr_d = rd_acc ? r_addr_q + 1'b1 : r_addr_q;
        count_d  = (wr_acc & ~rd_acc) ? count_q + 1'b1 :
                   (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
        // a new error event wins over a coincident clear
        ovf_d    = (wr & full_q & ~rd) | (ovf_q & ~clr_err);
        udf_d    = (rd & empty_q & ~wr) | (udf_q & ~clr_err);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            w_addr_q <= '0;
            r_addr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            w_addr_q <= w_addr_d;
            r_addr_q <= r_addr_d;
            count_q  <= count_d;
            full_q   <= count_d == DEPTH;
            empty_q  <= count_d == '0;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
    assign w_addr       = w_addr_q;
    assign r_addr       = r_addr_q;
    assign wr_en        = wr_acc;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = 32'(count_q) >= AF_LEVEL;
    assign almost_empty = 32'(count_q) <= AE_LEVEL;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule
